// File: rtl/starfield_pkg.sv
// Shared constants and the LFSR step function for the parallax starfield.
// Hash multipliers are 16-bit odd constants; the products are truncated to 16 bits.
package starfield_pkg;

    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] HASH_MUL_COL   = 16'h9E37;
    localparam logic [15:0] HASH_MUL_ROW   = 16'h79B9;
    localparam logic [15:0] HASH_MUL_LAYER = 16'h3C6F;

    // 16-bit Galois LFSR, right-shifting.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/starfield_hash.sv
// Combinational per-layer star hash: decides whether (col,row) holds a star
// and exposes the top nibble of the hash as the twinkle key.
module starfield_hash
    import starfield_pkg::*;
#(
    parameter int          COL_BITS  = 10,
    parameter int          ROW_BITS  = 7,
    parameter int          LAYER_IDX = 0,
    parameter logic [11:0] DENSITY   = 12'd24
) (
    input  logic [COL_BITS-1:0] col_i,
    input  logic [ROW_BITS-1:0] row_i,
    output logic                star_raw_o,
    output logic [3:0]          key_o
);

    localparam logic [15:0] LAYER_TERM = 16'(16'(LAYER_IDX + 1) * HASH_MUL_LAYER);

    logic [15:0] h;

    assign h          = (16'(col_i) * HASH_MUL_COL) ^ (16'(row_i) * HASH_MUL_ROW) ^ LAYER_TERM;
    assign star_raw_o = (h[11:0] < DENSITY);
    assign key_o      = h[15:12];

endmodule

// File: rtl/starfield_layers.sv
// Multi-layer parallax starfield: per-layer fractional scroll accumulators,
// a frame-rate twinkle LFSR, and a 2-stage pixel pipeline into a priority encoder.
module starfield_layers
    import starfield_pkg::*;
#(
    parameter int          LAYERS    = 3,
    parameter int          COL_BITS  = 10,
    parameter int          ROW_BITS  = 7,
    parameter int          FRAC_BITS = 2,
    parameter int          SPD_BITS  = 4,
    parameter int          PAL_BITS  = 3,
    parameter logic [11:0] DENSITY   = 12'd24
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_start,
    input  logic                         scroll_en,
    input  logic                         twinkle_en,
    input  logic [LAYERS*SPD_BITS-1:0]   speed,
    input  logic                         pixel_valid,
    input  logic [COL_BITS-1:0]          DrawX,
    input  logic [ROW_BITS-1:0]          DrawY,
    output logic [PAL_BITS-1:0]          PalInd,
    output logic                         PalInd_valid
);

    localparam int ACC_W = ROW_BITS + FRAC_BITS;

    logic [ACC_W-1:0]    acc_q [LAYERS];
    logic [ACC_W-1:0]    acc_d [LAYERS];
    logic [15:0]         lfsr_q, lfsr_d;

    logic [ROW_BITS-1:0] row_d [LAYERS];
    logic [ROW_BITS-1:0] row_q [LAYERS];
    logic [COL_BITS-1:0] col_q;
    logic                vld1_q;
    logic [3:0]          twk_key_q;
    logic                twk_en_q;

    logic [LAYERS-1:0]   star_raw;
    logic [3:0]          key [LAYERS];
    logic [LAYERS-1:0]   star;
    logic [PAL_BITS-1:0] pal_d, pal_q;
    logic                vld2_q;

    always_comb begin
        for (int l = 0; l < LAYERS; l++) begin
            acc_d[l] = acc_q[l];
            if (frame_start && scroll_en)
                acc_d[l] = acc_q[l] + ACC_W'(speed[l*SPD_BITS +: SPD_BITS]);
            row_d[l] = DrawY + acc_q[l][ACC_W-1:FRAC_BITS];
        end
        lfsr_d = frame_start ? lfsr_step(lfsr_q) : lfsr_q;
    end

    // The twinkle key is captured with the pixel so a pixel coincident with
    // frame_start is judged against the pre-update LFSR.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int l = 0; l < LAYERS; l++) begin
                acc_q[l] <= '0;
                row_q[l] <= '0;
            end
            lfsr_q    <= LFSR_SEED;
            col_q     <= '0;
            vld1_q    <= 1'b0;
            twk_key_q <= '0;
            twk_en_q  <= 1'b0;
            pal_q     <= '0;
            vld2_q    <= 1'b0;
        end else begin
            for (int l = 0; l < LAYERS; l++) begin
                acc_q[l] <= acc_d[l];
                row_q[l] <= row_d[l];
            end
            lfsr_q    <= lfsr_d;
            col_q     <= DrawX;
            vld1_q    <= pixel_valid;
            twk_key_q <= lfsr_q[3:0];
            twk_en_q  <= twinkle_en;
            pal_q     <= pal_d;
            vld2_q    <= vld1_q;
        end
    end

    for (genvar g = 0; g < LAYERS; g++) begin : g_layer
        starfield_hash #(
            .COL_BITS  (COL_BITS),
            .ROW_BITS  (ROW_BITS),
            .LAYER_IDX (g),
            .DENSITY   (DENSITY)
        ) u_hash (
            .col_i      (col_q),
            .row_i      (row_q[g]),
            .star_raw_o (star_raw[g]),
            .key_o      (key[g])
        );
        assign star[g] = star_raw[g] && !(twk_en_q && (key[g] == twk_key_q));
    end

    // Lowest layer index wins: it is the nearest layer.
    always_comb begin
        pal_d = '0;
        for (int l = LAYERS - 1; l >= 0; l--) begin
            if (star[l])
                pal_d = PAL_BITS'(l + 1);
        end
        if (!vld1_q)
            pal_d = '0;
    end

    assign PalInd       = pal_q;
    assign PalInd_valid = vld2_q;

endmodule
